// File: rtl/key_schedule_engine.sv
// Iterative AES-128/192/256 key expansion: one schedule word per clock into a
// round-key store that the cipher datapath reads combinationally by index.
`timescale 1ns/1ps
module key_schedule_engine #(
  parameter int unsigned MAX_KEY_BITS = 256
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [255:0] key,
  input  logic [1:0]   key_len,
  output logic         busy,
  output logic         done,
  output logic         error,
  output logic         schedule_valid,
  output logic [3:0]   num_rounds,
  input  logic [3:0]   rk_index,
  output logic [127:0] rk_out,
  output logic         rk_valid
);

  localparam int unsigned NR_MAX       = MAX_KEY_BITS / 32 + 6;
  localparam int unsigned DEPTH        = 4 * (NR_MAX + 1);
  localparam int unsigned MAX_LEN_CODE = (MAX_KEY_BITS - 128) / 64;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic {IDLE, EXPAND} state_t;

  state_t       state, state_d;
  logic [31:0]  w [DEPTH];
  logic [5:0]   i;
  logic [2:0]   imod;
  logic [3:0]   nk;
  logic [3:0]   nr_l;
  logic [5:0]   total;
  logic [7:0]   rcon;
  logic         done_q, error_q, sv_q;
  logic [3:0]   nr_q;

  logic         accept, reject, step, last, len_legal;
  logic [3:0]   nk_new, nr_new;
  logic [5:0]   total_new;
  logic [31:0]  prev, rot, sub_in, sub_out, temp, new_word;
  logic [5:0]   base;

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [10:0] off;
    off  = {~x, 3'b000};
    sbox = SBOX[off +: 8];
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] a);
    subword = {sbox(a[31:24]), sbox(a[23:16]), sbox(a[15:8]), sbox(a[7:0])};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] r);
    xtime = {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
  endfunction

  assign len_legal = (key_len != 2'b11) && (32'(key_len) <= MAX_LEN_CODE);
  assign nk_new    = 4'(4 + 2 * 32'(key_len));
  assign nr_new    = 4'(10 + 2 * 32'(key_len));
  assign total_new = 6'(4 * (32'(nr_new) + 1));

  // Next-state and control strobes
  always_comb begin
    state_d = state;
    accept  = 1'b0;
    reject  = 1'b0;
    step    = 1'b0;
    last    = 1'b0;
    case (state)
      IDLE: begin
        if (key_valid) begin
          if (len_legal) begin
            accept  = 1'b1;
            state_d = EXPAND;
          end else begin
            reject = 1'b1;
          end
        end
      end
      EXPAND: begin
        step = 1'b1;
        if (i == total - 6'd1) begin
          last    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // One shared SubWord serves both the RotWord path and the Nk=8 mid-key path
  always_comb begin
    prev     = w[i - 6'd1];
    rot      = {prev[23:0], prev[31:24]};
    sub_in   = (imod == 3'd0) ? rot : prev;
    sub_out  = subword(sub_in);
    if (imod == 3'd0)
      temp = sub_out ^ {rcon, 24'h0};
    else if (nk == 4'd8 && imod == 3'd4)
      temp = sub_out;
    else
      temp = prev;
    new_word = w[i - 6'(nk)] ^ temp;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      state <= IDLE;
    else
      state <= state_d;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int j = 0; j < int'(DEPTH); j++) w[j] <= '0;
      i       <= '0;
      imod    <= '0;
      nk      <= '0;
      nr_l    <= '0;
      total   <= '0;
      rcon    <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      sv_q    <= 1'b0;
      nr_q    <= '0;
    end else begin
      done_q  <= last;
      error_q <= reject;
      if (accept) begin
        for (int j = 0; j < 8; j++)
          if (32'(j) < 32'(nk_new)) w[j] <= key[(255 - 32 * j) -: 32];
        nk    <= nk_new;
        nr_l  <= nr_new;
        total <= total_new;
        i     <= 6'(nk_new);
        imod  <= '0;
        rcon  <= 8'h01;
        sv_q  <= 1'b0;
      end
      if (step) begin
        w[i] <= new_word;
        i    <= i + 6'd1;
        imod <= ({1'b0, imod} == nk - 4'd1) ? 3'd0 : imod + 3'd1;
        if (imod == 3'd0) rcon <= xtime(rcon);
      end
      if (last) begin
        sv_q <= 1'b1;
        nr_q <= nr_l;
      end
    end
  end

  assign key_ready      = (state == IDLE);
  assign busy           = (state == EXPAND);
  assign done           = done_q;
  assign error          = error_q;
  assign schedule_valid = sv_q;
  assign num_rounds     = nr_q;

  // Indices past the store depth read as zero rather than wrapping
  always_comb begin
    base   = {rk_index, 2'b00};
    rk_out = '0;
    if (32'(base) < DEPTH)
      rk_out = {w[base], w[base + 6'd1], w[base + 6'd2], w[base + 6'd3]};
  end

  assign rk_valid = sv_q && (rk_index <= nr_q);

endmodule

// File: tb/tb_key_schedule_engine.sv
// Self-checking bench for key_schedule_engine using FIPS-197 expansion vectors.
`timescale 1ns/1ps
module tb_key_schedule_engine;

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'hdeadbeef0123456789abcdeffeedface};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'hcafef00d55aa55aa};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  logic         clock = 1'b0;
  logic         reset_n;
  logic         key_valid, key_valid128;
  logic [255:0] key;
  logic [1:0]   key_len, key_len128;
  logic [3:0]   rk_index;
  logic         key_ready, busy, done, error, schedule_valid, rk_valid;
  logic [3:0]   num_rounds;
  logic [127:0] rk_out;
  logic         key_ready128, busy128, done128, error128, sv128, rk_valid128;
  logic [3:0]   nr128;
  logic [127:0] rk_out128;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string        tag;
    logic [3:0]   idx;
    logic [127:0] rk;
    logic         vld;
  } exp_t;
  exp_t sb[$];

  always #5 clock = ~clock;

  key_schedule_engine #(.MAX_KEY_BITS(256)) dut (
    .clock(clock), .reset_n(reset_n), .key_valid(key_valid), .key_ready(key_ready),
    .key(key), .key_len(key_len), .busy(busy), .done(done), .error(error),
    .schedule_valid(schedule_valid), .num_rounds(num_rounds), .rk_index(rk_index),
    .rk_out(rk_out), .rk_valid(rk_valid)
  );

  key_schedule_engine #(.MAX_KEY_BITS(128)) dut128 (
    .clock(clock), .reset_n(reset_n), .key_valid(key_valid128), .key_ready(key_ready128),
    .key(key), .key_len(key_len128), .busy(busy128), .done(done128), .error(error128),
    .schedule_valid(sv128), .num_rounds(nr128), .rk_index(rk_index),
    .rk_out(rk_out128), .rk_valid(rk_valid128)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input logic [3:0] idx, input logic [127:0] rk, input logic vld);
    exp_t e;
    e.tag = tag; e.idx = idx; e.rk = rk; e.vld = vld;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      rk_index = e.idx;
      #1;
      if (e.vld) chk({e.tag, "_rk"}, rk_out, e.rk);
      chk({e.tag, "_vld"}, 128'(rk_valid), 128'(e.vld));
    end
  endtask

  // Wait for done from just after an edge, flagging ready/busy errors en route
  task automatic wait_done(input string tag, input int exp_cyc);
    int cyc = 0;
    int bad = 0;
    while (!done && cyc < 200) begin
      @(posedge clock); #1;
      cyc++;
      if (!done && (key_ready || !busy)) bad++;
    end
    chk({tag, "_latency"}, 128'(cyc), 128'(exp_cyc));
    chk({tag, "_ready_busy"}, 128'(bad), 128'(0));
    chk({tag, "_done_state"}, 128'({key_ready, busy, schedule_valid}), 128'(3'b101));
  endtask

  task automatic do_key(input string tag, input logic [255:0] k, input logic [1:0] len,
                        input int exp_cyc, input logic [3:0] exp_nr);
    @(posedge clock); #1;
    key = k; key_len = len; key_valid = 1'b1;
    chk({tag, "_ready"}, 128'(key_ready), 128'(1));
    @(posedge clock); #1;
    key_valid = 1'b0;
    chk({tag, "_busy"}, 128'({busy, schedule_valid}), 128'(2'b10));
    wait_done(tag, exp_cyc);
    chk({tag, "_nr"}, 128'(num_rounds), 128'(exp_nr));
    @(posedge clock); #1;
    chk({tag, "_done_fall"}, 128'(done), 128'(0));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_flags"}, 128'({key_ready, busy, done, error, schedule_valid, rk_valid}), 128'(6'b100000));
    chk({tag, "_nr"}, 128'(num_rounds), 128'(0));
    chk({tag, "_rk"}, rk_out, 128'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int dn;
    reset_n = 1'b0; key_valid = 1'b0; key_valid128 = 1'b0;
    key = '0; key_len = 2'b00; key_len128 = 2'b00; rk_index = 4'd10;
    repeat (3) @(posedge clock);
    #1;
    chk_reset_vals("reset");
    reset_n = 1'b1;

    // AES-128
    push("a128_i0", 4'd0, 128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b1);
    push("a128_i1", 4'd1, 128'ha0fafe1788542cb123a339392a6c7605, 1'b1);
    push("a128_i10", 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b1);
    push("a128_i11", 4'd11, 128'h0, 1'b0);
    do_key("a128", K128, 2'b00, 40, 4'd10);
    drain();

    // Illegal key_len keeps the stored schedule
    @(posedge clock); #1;
    key = K256; key_len = 2'b11; key_valid = 1'b1;
    key_len128 = 2'b10; key_valid128 = 1'b1;
    @(posedge clock); #1;
    key_valid = 1'b0; key_valid128 = 1'b0;
    chk("illegal_error", 128'({error, busy, key_ready}), 128'(3'b101));
    chk("max128_error", 128'({error128, busy128, key_ready128}), 128'(3'b101));
    @(posedge clock); #1;
    chk("illegal_error_fall", 128'({error, error128}), 128'(2'b00));
    chk("max128_idle", 128'({done128, sv128, rk_valid128, nr128}), 128'(0));
    chk("max128_rk", rk_out128, 128'(0));
    chk("illegal_sv", 128'({schedule_valid, num_rounds}), 128'({1'b1, 4'd10}));
    push("illegal_i10", 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b1);
    drain();

    // AES-192
    push("a192_i0", 4'd0, 128'h8e73b0f7da0e6452c810f32b809079e5, 1'b1);
    push("a192_i12", 4'd12, 128'he98ba06f448c773c8ecc720401002202, 1'b1);
    push("a192_i13", 4'd13, 128'h0, 1'b0);
    do_key("a192", K192, 2'b01, 46, 4'd12);
    drain();

    // AES-256
    push("a256_i0", 4'd0, 128'h603deb1015ca71be2b73aef0857d7781, 1'b1);
    push("a256_i14", 4'd14, 128'hfe4890d1e6188d0b046df344706c631e, 1'b1);
    push("a256_i15", 4'd15, 128'h0, 1'b0);
    do_key("a256", K256, 2'b10, 52, 4'd14);
    drain();

    // Back-to-back: 128-bit key held during a 256-bit expansion
    @(posedge clock); #1;
    key = K256; key_len = 2'b10; key_valid = 1'b1;
    @(posedge clock); #1;
    key = K128; key_len = 2'b00;
    wait_done("b2b_first", 52);
    @(posedge clock); #1;
    key_valid = 1'b0;
    chk("b2b_accept", 128'({schedule_valid, busy, done, key_ready}), 128'(4'b0100));
    wait_done("b2b_second", 40);
    chk("b2b_nr", 128'(num_rounds), 128'(10));
    push("b2b_i1", 4'd1, 128'ha0fafe1788542cb123a339392a6c7605, 1'b1);
    push("b2b_i10", 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b1);
    push("b2b_i14", 4'd14, 128'h0, 1'b0);
    drain();

    // Reset in the middle of an AES-192 expansion
    rk_index = 4'd0;
    @(posedge clock); #1;
    key = K192; key_len = 2'b01; key_valid = 1'b1;
    @(posedge clock); #1;
    key_valid = 1'b0;
    repeat (19) @(posedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    chk_reset_vals("midreset");
    @(posedge clock); #1;
    reset_n = 1'b1;
    dn = 0;
    repeat (40) begin
      @(posedge clock); #1;
      if (done || schedule_valid) dn++;
    end
    chk("midreset_no_done", 128'(dn), 128'(0));
    push("post_i1", 4'd1, 128'ha0fafe1788542cb123a339392a6c7605, 1'b1);
    push("post_i10", 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b1);
    do_key("post", K128, 2'b00, 40, 4'd10);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
